// File: rtl/uart_tx_frame.sv
// Serial UART transmitter: start bit, LSB-first data, optional even/odd parity, stop bit.
// Sends one bit per CLK cycle and can start the next frame directly after a stop bit.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         bit_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_reg, data_nxt;
  logic                  par_en_reg, par_en_nxt;
  logic                  par_typ_reg, par_typ_nxt;
  logic                  accept;
  logic                  tx_nxt, busy_nxt;

  assign accept = DATA_VALID && ((state == S_IDLE) || (state == S_STOP));

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = bit_cnt;
    data_nxt    = data_reg;
    par_en_nxt  = par_en_reg;
    par_typ_nxt = par_typ_reg;
    if (accept) begin
      data_nxt    = P_DATA;
      par_en_nxt  = PAR_EN;
      par_typ_nxt = PAR_TYP;
    end
    case (state)
      S_IDLE:   if (accept) state_nxt = S_START;
      S_START: begin
        state_nxt = S_DATA;
        cnt_nxt   = '0;
      end
      S_DATA: begin
        cnt_nxt = bit_cnt + 1'b1;
        if (bit_cnt == CW'(DATA_WIDTH - 1))
          state_nxt = par_en_reg ? S_PARITY : S_STOP;
      end
      S_PARITY: state_nxt = S_STOP;
      S_STOP:   state_nxt = accept ? S_START : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    tx_nxt   = 1'b1;
    busy_nxt = 1'b1;
    case (state_nxt)
      S_IDLE:   busy_nxt = 1'b0;
      S_START:  tx_nxt   = 1'b0;
      S_DATA:   tx_nxt   = data_nxt[cnt_nxt];
      S_PARITY: tx_nxt   = (^data_nxt) ^ par_typ_nxt;
      S_STOP:   tx_nxt   = 1'b1;
      default: begin
        tx_nxt   = 1'b1;
        busy_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      bit_cnt     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= cnt_nxt;
      data_reg    <= data_nxt;
      par_en_reg  <= par_en_nxt;
      par_typ_reg <= par_typ_nxt;
      TX_OUT      <= tx_nxt;
      Busy        <= busy_nxt;
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serializing UART transmitter. Accepts a parallel byte with a valid strobe and emits one asynchronous serial frame on `TX_OUT`: start bit, 8 data bits LSB first, optional parity bit, stop bit. It runs on the TX baud clock, one serial bit per `CLK` cycle. It is the transmit counterpart of the UART RX sampling/deserializing chain and sits between the system-side TX FIFO/synchronizer and the serial pin.

## Interface
- `DATA_WIDTH`, 8, payload bits per frame. Counter widths derive from it; the frame fields below assume 8.
- `CLK`  in  1  TX baud clock; every state advance happens on its rising edge.
- `RST`  in  1  Reset: **synchronous, active-high**, sampled on the rising edge of `CLK`.
- `P_DATA`  in  DATA_WIDTH  Payload byte, captured only on acceptance.
- `DATA_VALID`  in  1  Request to send `P_DATA`.
- `PAR_EN`  in  1  1 inserts a parity bit. Captured on acceptance.
- `PAR_TYP`  in  1  0 selects even parity, 1 selects odd. Captured on acceptance.
- `TX_OUT`  out  1  Serial line, registered. Idles high.
- `Busy`  out  1  Registered. High from the first cycle of the start bit through the stop-bit cycle.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Acceptance.** A request is accepted on an edge where `DATA_VALID`=1 and the state is IDLE or STOP.
  - On acceptance, capture `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers and go to START.
  - Input changes after acceptance have no effect on the frame in progress.
  - `DATA_VALID` in START, DATA or PARITY is ignored. It is not queued.
- **IDLE:** `TX_OUT`=1, `Busy`=0.
- **START:** `TX_OUT`=0 for one cycle, then go to DATA with the bit counter at 0.
- **DATA:** `TX_OUT`=data[bit_cnt] for one cycle per bit, LSB first.
  - The 3-bit counter increments each cycle.
  - At count 7, go to PARITY if the captured `PAR_EN`=1, otherwise go to STOP.
- **PARITY:** `TX_OUT` = XOR-reduce(captured data) XOR captured `PAR_TYP`.
  - Even mode: the total number of ones across data plus parity is even.
  - Odd mode: that total is odd.
- **STOP:** `TX_OUT`=1 for one cycle.
  - Next state is START if a new request is accepted on this edge (back-to-back frame, no idle gap).
  - Otherwise next state is IDLE.
- **Busy:** 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- **Output registration.** `TX_OUT` and `Busy` are registered. They are decoded from the next state and updated on the same edge as the state register, so there is no combinational path from any input to any output.

## Timing
- **Reset.** An edge with `RST`=1 forces: state IDLE, `TX_OUT`=1, `Busy`=0, bit counter 0, data/parity-config registers 0.
  - This applies mid-frame: the frame is aborted and the line returns high on that edge.
  - `DATA_VALID` on the reset edge is ignored.
  - The first acceptance can occur on the first edge with `RST`=0.
- **Latency.** Acceptance on edge k gives `TX_OUT`=0 and `Busy`=1 in the cycle after edge k.
- **Frame length** (start through stop): 10 cycles without parity, 11 with parity.
  - Data bit i appears in cycle k+2+i.
  - Parity appears in cycle k+10.
  - Stop appears in cycle k+10 (no parity) or k+11 (parity).
- **Frame end.** Without a new request, `Busy` falls and the line stays high in the cycle after the stop bit.
- **Back-to-back.** Acceptance on the stop-bit edge puts the next start bit in the very next cycle. `Busy` stays 1 continuously.
- **Parity settings** apply per frame: consecutive frames may differ in `PAR_EN` or `PAR_TYP`.

## Test plan
- **No parity.** Reset, then `P_DATA`=0xA5, `PAR_EN`=0, one-cycle `DATA_VALID`.
  - Required `TX_OUT`: 0,1,0,1,0,0,1,0,1,1, then idle 1.
  - `Busy` high for exactly 10 cycles.
- **Even parity.** 0xA5, `PAR_EN`=1, `PAR_TYP`=0.
  - Parity bit 0 in cycle k+10, stop in k+11.
  - `Busy` high for 11 cycles.
  - Repeat with `PAR_TYP`=1: parity bit 1.
- **Odd parity.** 0x01, `PAR_EN`=1, `PAR_TYP`=1.
  - Data 1,0,0,0,0,0,0,0, parity 0, stop 1.
- **Back-to-back.** Hold `DATA_VALID`=1, sending 0x3C then 0xC3 (0x3C accepted from IDLE, 0xC3 during its STOP), no parity.
  - Two contiguous 10-bit frames, start bit of the second immediately after the first stop.
  - `Busy` never drops.
  - `DATA_VALID` during the data bits causes no extra frame.
- **Input stability.** Change `P_DATA` and `PAR_TYP` every cycle mid-frame.
  - Transmitted bits match the values captured at acceptance.
- **Reset mid-frame.** Assert `RST` during data bit 3.
  - On that edge: `TX_OUT`=1, `Busy`=0.
  - A new request after `RST` is released transmits a complete, correct frame.
